// File: rtl/uart_mem_host_pkg.sv
// Shared header for the UART memory host and the processor top.
// Holds the default width constants, the host FSM state encodings and the
// bytes-per-word helper used to size the byte serializer/assembler.
package uart_mem_host_pkg;

   localparam int DEF_MEM_WORD_LENGTH = 12;
   localparam int DEF_MEM_ADDR_LENGTH = 12;
   localparam int DEF_UART_WIDTH      = 8;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      TX_FETCH = 3'd1,
      TX_LOAD  = 3'd2,
      TX_SEND  = 3'd3,
      TX_BUSY  = 3'd4,
      TX_WAIT  = 3'd5,
      RX       = 3'd6,
      DONE     = 3'd7
   } hostState_e;

   // Number of UART bytes needed to carry one memory word.
   function automatic int bytesPerWord(input int wordLen, input int byteLen);
      return (wordLen + byteLen - 1) / byteLen;
   endfunction

   // Width of a byte index counter; at least one bit even for BPW=1.
   function automatic int idxWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_word_assembler.sv
// Collects received UART bytes (LSB byte first) into memory words and
// issues one sink write per completed word.
// Ports:
//   clk, rstN      clock, synchronous active-low reset
//   clear          start of a new run: zero byte index and sink address
//   rxEn           host is in the RX state; bytes outside it are dropped
//   newRxByte      one-cycle pulse, byteFromUart valid
//   byteFromUart   received byte
//   wordComplete   combinational: the byte taken this cycle completes a word
//   sinkAddr/Data  sink RAM write address/data, valid while sinkWrEn
//   sinkWrEn       one-cycle write strobe, the cycle after the last byte
module uart_word_assembler
   import uart_mem_host_pkg::*;
#(
   parameter int MEM_WORD_LENGTH = DEF_MEM_WORD_LENGTH,
   parameter int MEM_ADDR_LENGTH = DEF_MEM_ADDR_LENGTH,
   parameter int UART_WIDTH      = DEF_UART_WIDTH
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic                       clear,
   input  logic                       rxEn,
   input  logic                       newRxByte,
   input  logic [UART_WIDTH-1:0]      byteFromUart,
   output logic                       wordComplete,
   output logic [MEM_ADDR_LENGTH-1:0] sinkAddr,
   output logic [MEM_WORD_LENGTH-1:0] sinkData,
   output logic                       sinkWrEn
);

   localparam int BPW = bytesPerWord(MEM_WORD_LENGTH, UART_WIDTH);
   localparam int IW  = idxWidth(BPW);
   localparam logic [IW-1:0]              LAST_IDX = IW'(BPW - 1);
   localparam logic [IW-1:0]              IDX_ONE  = IW'(1);
   localparam logic [MEM_ADDR_LENGTH-1:0] ADDR_ONE = MEM_ADDR_LENGTH'(1);

   logic [IW-1:0]             byteIdx;
   logic [BPW*UART_WIDTH-1:0] partial;
   logic [BPW*UART_WIDTH-1:0] merged;
   logic                      take;

   assign take         = rxEn && newRxByte;
   assign wordComplete = take && (byteIdx == LAST_IDX);

   // Word as it stands once the incoming byte is dropped into its slot.
   always_comb begin
      merged = partial;
      merged[int'(byteIdx)*UART_WIDTH +: UART_WIDTH] = byteFromUart;
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         byteIdx  <= '0;
         partial  <= '0;
         sinkAddr <= '0;
         sinkData <= '0;
         sinkWrEn <= 1'b0;
      end else begin
         sinkWrEn <= wordComplete;
         // Address advances after the write cycle, so the final word of a
         // full-depth run leaves the counter wrapped to 0.
         if (sinkWrEn)
            sinkAddr <= sinkAddr + ADDR_ONE;
         if (clear) begin
            byteIdx  <= '0;
            sinkAddr <= '0;
         end else if (take) begin
            partial <= merged;
            if (wordComplete) begin
               byteIdx  <= '0;
               // Padding bits of the top byte are dropped here.
               sinkData <= merged[MEM_WORD_LENGTH-1:0];
            end else begin
               byteIdx <= byteIdx + IDX_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/uart_mem_host.sv
// Host-side memory loader: streams txWordCount words from a source RAM out
// through a uart_system byte port (LSB byte first, zero-padded), then
// collects rxWordCount words back into a sink RAM.
// Ports:
//   clk, rstN                 clock, synchronous active-low reset
//   startN                    active-low start, honoured in IDLE/DONE only
//   txWordCount, rxWordCount  word counts, latched at start (up to 2^AW)
//   srcAddr, srcData          source RAM, 1-cycle read latency
//   sinkAddr/Data/WrEn        sink RAM write port
//   txByteReady, txByteStart, byteToUart   uart_system transmit handshake
//   newRxByte, byteFromUart   uart_system receive strobe/data
//   busy, txDone, rxDone      status; flags held until the next start
module uart_mem_host
   import uart_mem_host_pkg::*;
#(
   parameter int MEM_WORD_LENGTH = DEF_MEM_WORD_LENGTH,
   parameter int MEM_ADDR_LENGTH = DEF_MEM_ADDR_LENGTH,
   parameter int UART_WIDTH      = DEF_UART_WIDTH
) (
   input  logic                       clk,
   input  logic                       rstN,
   input  logic                       startN,
   input  logic [MEM_ADDR_LENGTH:0]   txWordCount,
   input  logic [MEM_ADDR_LENGTH:0]   rxWordCount,
   output logic [MEM_ADDR_LENGTH-1:0] srcAddr,
   input  logic [MEM_WORD_LENGTH-1:0] srcData,
   output logic [MEM_ADDR_LENGTH-1:0] sinkAddr,
   output logic [MEM_WORD_LENGTH-1:0] sinkData,
   output logic                       sinkWrEn,
   input  logic                       txByteReady,
   output logic                       txByteStart,
   output logic [UART_WIDTH-1:0]      byteToUart,
   input  logic                       newRxByte,
   input  logic [UART_WIDTH-1:0]      byteFromUart,
   output logic                       busy,
   output logic                       txDone,
   output logic                       rxDone
);

   localparam int BPW = bytesPerWord(MEM_WORD_LENGTH, UART_WIDTH);
   localparam int IW  = idxWidth(BPW);
   localparam int SW  = BPW * UART_WIDTH;
   localparam logic [IW-1:0]              LAST_IDX = IW'(BPW - 1);
   localparam logic [IW-1:0]              IDX_ONE  = IW'(1);
   localparam logic [MEM_ADDR_LENGTH-1:0] ADDR_ONE = MEM_ADDR_LENGTH'(1);
   localparam logic [MEM_ADDR_LENGTH:0]   CNT_ONE  = (MEM_ADDR_LENGTH+1)'(1);

   hostState_e                state;
   logic [MEM_ADDR_LENGTH:0]  txTotal, rxTotal, txSent, rxGot;
   logic [SW-1:0]             srcPad, txWord;
   logic [IW-1:0]             txByteIdx;
   logic                      startAccept, wordComplete;

   assign startAccept = ((state == IDLE) || (state == DONE)) && !startN;
   assign busy        = !((state == IDLE) || (state == DONE));
   // Decoded from the registered state so the pulse lands inside TX_SEND;
   // the FSM leaves TX_SEND on the same edge, so it lasts one cycle.
   assign txByteStart = (state == TX_SEND) && txByteReady;

   always_comb begin
      srcPad = '0;
      srcPad[MEM_WORD_LENGTH-1:0] = srcData;
   end

   uart_word_assembler #(
      .MEM_WORD_LENGTH (MEM_WORD_LENGTH),
      .MEM_ADDR_LENGTH (MEM_ADDR_LENGTH),
      .UART_WIDTH      (UART_WIDTH)
   ) uAsm (
      .clk          (clk),
      .rstN         (rstN),
      .clear        (startAccept),
      .rxEn         (state == RX),
      .newRxByte    (newRxByte),
      .byteFromUart (byteFromUart),
      .wordComplete (wordComplete),
      .sinkAddr     (sinkAddr),
      .sinkData     (sinkData),
      .sinkWrEn     (sinkWrEn)
   );

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state      <= IDLE;
         srcAddr    <= '0;
         txTotal    <= '0;
         rxTotal    <= '0;
         txSent     <= '0;
         rxGot      <= '0;
         txWord     <= '0;
         txByteIdx  <= '0;
         byteToUart <= '0;
         txDone     <= 1'b0;
         rxDone     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (!startN) begin
                  srcAddr <= '0;
                  txSent  <= '0;
                  rxGot   <= '0;
                  txTotal <= txWordCount;
                  rxTotal <= rxWordCount;
                  txDone  <= 1'b0;
                  rxDone  <= 1'b0;
                  if (txWordCount != '0) begin
                     state <= TX_FETCH;
                  end else if (rxWordCount != '0) begin
                     txDone <= 1'b1;   // empty TX phase is trivially complete
                     state  <= RX;
                  end else begin
                     txDone <= 1'b1;
                     rxDone <= 1'b1;
                     state  <= DONE;
                  end
               end
            end
            TX_FETCH: state <= TX_LOAD;
            TX_LOAD: begin
               // Present the low byte now so it is stable before the pulse.
               byteToUart <= srcPad[UART_WIDTH-1:0];
               txWord     <= srcPad >> UART_WIDTH;
               txByteIdx  <= '0;
               state      <= TX_SEND;
            end
            TX_SEND: if (txByteReady) state <= TX_BUSY;
            TX_BUSY: if (!txByteReady) state <= TX_WAIT;
            TX_WAIT: begin
               if (txByteReady) begin
                  if (txByteIdx != LAST_IDX) begin
                     txByteIdx  <= txByteIdx + IDX_ONE;
                     byteToUart <= txWord[UART_WIDTH-1:0];
                     txWord     <= txWord >> UART_WIDTH;
                     state      <= TX_SEND;
                  end else if (txSent != txTotal - CNT_ONE) begin
                     srcAddr <= srcAddr + ADDR_ONE;
                     txSent  <= txSent + CNT_ONE;
                     state   <= TX_FETCH;
                  end else begin
                     txDone <= 1'b1;
                     if (rxTotal == '0) begin
                        rxDone <= 1'b1;
                        state  <= DONE;
                     end else begin
                        state <= RX;
                     end
                  end
               end
            end
            RX: begin
               if (wordComplete) begin
                  // The write strobe for this last word follows in DONE.
                  if (rxGot == rxTotal - CNT_ONE) begin
                     rxDone <= 1'b1;
                     state  <= DONE;
                  end else begin
                     rxGot <= rxGot + CNT_ONE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mem_host.sv
module tb_uart_mem_host;

   localparam int AW    = 12;
   localparam int WW    = 12;
   localparam int BW    = 8;
   localparam int DEPTH = 4096;

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          startN = 1'b1;
   logic [AW:0]   txWordCount = '0;
   logic [AW:0]   rxWordCount = '0;
   logic [AW-1:0] srcAddr, sinkAddr;
   logic [WW-1:0] srcData, sinkData;
   logic          sinkWrEn, txByteReady, txByteStart, busy, txDone, rxDone;
   logic          newRxByte = 1'b0;
   logic [BW-1:0] byteToUart;
   logic [BW-1:0] byteFromUart = '0;

   logic [WW-1:0] srcMem  [DEPTH];
   logic [WW-1:0] sinkMem [DEPTH];

   logic          rdyReg = 1'b1;
   logic          holdLow = 1'b0;
   int            busyCnt = 0;
   int            uartLat = 3;

   logic [BW-1:0]    expTx[$];
   logic [BW-1:0]    loopQ[$];
   logic [AW+WW-1:0] expSink[$];

   int            checks = 0;
   int            errors = 0;
   int            pulseCnt = 0;
   logic          prevStart = 1'b0;
   logic [BW-1:0] lastByte = '0;

   always #5 clk = ~clk;

   uart_mem_host #(
      .MEM_WORD_LENGTH (WW),
      .MEM_ADDR_LENGTH (AW),
      .UART_WIDTH      (BW)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .startN       (startN),
      .txWordCount  (txWordCount),
      .rxWordCount  (rxWordCount),
      .srcAddr      (srcAddr),
      .srcData      (srcData),
      .sinkAddr     (sinkAddr),
      .sinkData     (sinkData),
      .sinkWrEn     (sinkWrEn),
      .txByteReady  (txByteReady),
      .txByteStart  (txByteStart),
      .byteToUart   (byteToUart),
      .newRxByte    (newRxByte),
      .byteFromUart (byteFromUart),
      .busy         (busy),
      .txDone       (txDone),
      .rxDone       (rxDone)
   );

   // Source RAM (1-cycle read) and sink RAM models.
   always @(posedge clk) srcData <= srcMem[srcAddr];
   always @(posedge clk) if (sinkWrEn) sinkMem[sinkAddr] <= sinkData;

   // UART transmitter model: goes not-ready for uartLat cycles per byte.
   always @(posedge clk) begin
      if (txByteStart && txByteReady) begin
         rdyReg  <= 1'b0;
         busyCnt <= uartLat;
      end else if (!rdyReg) begin
         if (busyCnt <= 1) rdyReg <= 1'b1;
         else              busyCnt <= busyCnt - 1;
      end
   end
   assign txByteReady = rdyReg & ~holdLow;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic startRun(input logic [AW:0] tx, input logic [AW:0] rx);
      txWordCount = tx;
      rxWordCount = rx;
      startN = 1'b0;
      step();
      startN = 1'b1;
   endtask

   task automatic pushWord(input logic [WW-1:0] w);
      expTx.push_back(w[7:0]);
      expTx.push_back({4'h0, w[11:8]});
   endtask

   task automatic checkIdleOutputs(input string pfx);
      chk({pfx, "Busy"},     busy,        0);
      chk({pfx, "TxDone"},   txDone,      0);
      chk({pfx, "RxDone"},   rxDone,      0);
      chk({pfx, "TxStart"},  txByteStart, 0);
      chk({pfx, "SinkWrEn"}, sinkWrEn,    0);
      chk({pfx, "SrcAddr"},  srcAddr,     0);
      chk({pfx, "SinkAddr"}, sinkAddr,    0);
      chk({pfx, "Byte"},     byteToUart,  0);
      chk({pfx, "SinkData"}, sinkData,    0);
   endtask

   // Scoreboard monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (txByteStart) begin
         pulseCnt++;
         chk("startRdy", txByteReady, 1);
         chk("startTwice", prevStart, 0);
         if (expTx.size() == 0) chk("txExtra", expTx.size(), 1);
         else                   chk("txByte", byteToUart, expTx.pop_front());
         loopQ.push_back(byteToUart);
         lastByte = byteToUart;
      end else if (!rdyReg) begin
         chk("txStable", byteToUart, lastByte);
      end
      if (sinkWrEn) begin
         if (expSink.size() == 0) chk("sinkExtra", expSink.size(), 1);
         else                     chk("sinkWr", {sinkAddr, sinkData}, expSink.pop_front());
      end
      prevStart = txByteStart;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int bad;
      step();
      step();
      rstN = 1'b1;
      checkIdleOutputs("rst");

      // Three words out, no receive phase.
      srcMem[0] = 12'h123; srcMem[1] = 12'hABC; srcMem[2] = 12'h00F;
      expTx.push_back(8'h23); expTx.push_back(8'h01);
      expTx.push_back(8'hBC); expTx.push_back(8'h0A);
      expTx.push_back(8'h0F); expTx.push_back(8'h00);
      startRun(13'd3, 13'd0);
      chk("aBusy", busy, 1);
      step();
      step();
      chk("aFirstStart", txByteStart, 1);
      chk("aFirstByte", byteToUart, 8'h23);
      for (int i = 0; i < 300 && !txDone; i++) step();
      chk("aTxDone", txDone, 1);
      chk("aBusyEnd", busy, 0);
      chk("aSrcAddr", srcAddr, 2);
      chk("aTxLeft", expTx.size(), 0);

      // Receive-only: two words, first byte in the first RX cycle.
      expSink.push_back({12'h000, 12'h234});
      expSink.push_back({12'h001, 12'hFFF});
      startRun(13'd0, 13'd2);
      chk("bBusy", busy, 1);
      chk("bTxDone", txDone, 1);
      newRxByte = 1'b1; byteFromUart = 8'h34;
      step();
      byteFromUart = 8'h02;
      step();
      newRxByte = 1'b0;
      chk("bWrLat", sinkWrEn, 1);
      step();
      newRxByte = 1'b1; byteFromUart = 8'hFF;
      step();
      byteFromUart = 8'h0F;
      step();
      newRxByte = 1'b0;
      chk("bRxDone", rxDone, 1);
      chk("bBusyEnd", busy, 0);
      chk("bWrLat2", sinkWrEn, 1);
      step();
      chk("bSinkAddr", sinkAddr, 2);
      chk("bSinkLeft", expSink.size(), 0);

      // Both counts zero.
      startRun(13'd0, 13'd0);
      chk("cBusy", busy, 0);
      chk("cTxDone", txDone, 1);
      chk("cRxDone", rxDone, 1);
      repeat (5) step();

      // Transmitter held not-ready.
      srcMem[0] = 12'h5A7;
      pushWord(12'h5A7);
      holdLow = 1'b1;
      startRun(13'd1, 13'd0);
      chk("dTxDoneClr", txDone, 0);
      chk("dRxDoneClr", rxDone, 0);
      base = pulseCnt;
      repeat (50) step();
      chk("dHoldNoStart", pulseCnt - base, 0);
      chk("dHoldBusy", busy, 1);
      chk("dHoldByte", byteToUart, 8'hA7);
      holdLow = 1'b0;
      for (int i = 0; i < 100 && !txDone; i++) step();
      chk("dTxDone", txDone, 1);
      chk("dPulses", pulseCnt - base, 2);

      // Stray bytes during TX, then reset after half a received word.
      srcMem[0] = 12'h321;
      pushWord(12'h321);
      startRun(13'd1, 13'd1);
      for (int i = 0; i < 300; i++) begin
         if (txDone) break;
         newRxByte = (i % 2 == 0);
         byteFromUart = 8'hEE;
         step();
      end
      newRxByte = 1'b0;
      chk("eTxDone", txDone, 1);
      chk("eInRx", busy, 1);
      newRxByte = 1'b1; byteFromUart = 8'h44;
      step();
      newRxByte = 1'b0;
      step();
      rstN = 1'b0;
      step();
      checkIdleOutputs("midRst");
      rstN = 1'b1;
      step();
      expSink.push_back({12'h000, 12'h211});
      startRun(13'd0, 13'd1);
      newRxByte = 1'b1; byteFromUart = 8'h11;
      step();
      byteFromUart = 8'h02;
      step();
      newRxByte = 1'b0;
      chk("eRxDone", rxDone, 1);
      step();
      chk("eSinkLeft", expSink.size(), 0);

      // Full-depth loopback.
      uartLat = 1;
      loopQ.delete();
      for (int i = 0; i < DEPTH; i++) begin
         srcMem[i] = WW'($urandom_range(0, DEPTH - 1));
         pushWord(srcMem[i]);
         expSink.push_back({AW'(i), srcMem[i]});
      end
      startRun(13'd4096, 13'd4096);
      for (int i = 0; i < 40000 && !txDone; i++) step();
      chk("fTxDone", txDone, 1);
      chk("fSrcAddr", srcAddr, 4095);
      chk("fLoopBytes", loopQ.size(), 2 * DEPTH);
      while (loopQ.size() > 0) begin
         newRxByte = 1'b1;
         byteFromUart = loopQ.pop_front();
         step();
      end
      newRxByte = 1'b0;
      chk("fRxDone", rxDone, 1);
      step();
      chk("fSinkWrap", sinkAddr, 0);
      repeat (5) step();
      chk("fBusy", busy, 0);
      chk("fSinkLeft", expSink.size(), 0);
      chk("fTxLeft", expTx.size(), 0);
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (sinkMem[i] !== srcMem[i]) bad++;
      chk("fSinkMem", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
